// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master launches an operation; the slave computes and returns the result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Bin,
        input  D, Bout, V, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
        output D, Bout, V, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first, through one full-subtractor cell and a
// registered borrow, wrapped in a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             busy, done;

    logic diff_bit;
    logic borrow_next;
    logic last_bit;

    // Full-subtractor cell on the current LSBs.
    assign diff_bit    = sa_q[0] ^ sb_q[0] ^ br_q;
    assign borrow_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign last_bit    = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // Datapath next values
    always_comb begin
        sa_d    = sa_q;
        sb_d    = sb_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        bout_d  = bout_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.A;
                    sb_d    = bus.B;
                    br_d    = bus.Bin;
                    cnt_d   = '0;
                    d_d     = '0;
                    a_msb_d = bus.A[WIDTH-1];
                    b_msb_d = bus.B[WIDTH-1];
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                d_d   = {diff_bit, d_q[WIDTH-1:1]};
                br_d  = borrow_next;
                cnt_d = cnt_q + CW'(1);
                // Final bit: diff_bit becomes the result MSB, so flags are set on entry to DONE.
                if (last_bit) begin
                    bout_d = borrow_next;
                    v_d    = (a_msb_q != b_msb_q) & (diff_bit != a_msb_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q    <= '0;
            sb_q    <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
        end
    end

    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed table plus multi-cycle corner sequences and a random sweep for
// serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus_if ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       v;
    } vec_t;

    vec_t tbl[6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive operands and start, return 1 time unit after the accepting edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        bus_if.A     = a;
        bus_if.B     = b;
        bus_if.Bin   = bin;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
    endtask

    // Count edges until done is seen (bounded), and how many samples had busy.
    task automatic wait_done(output int edges, output int busy_cnt, output int overlap);
        edges    = 0;
        busy_cnt = 0;
        overlap  = 0;
        while (!bus_if.done && edges < 40) begin
            if (bus_if.busy) busy_cnt++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (bus_if.busy && bus_if.done) overlap = 1;
    endtask

    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic bin, input logic [7:0] ed, input logic eb, input logic ev);
        int edges, bcnt, ovl;
        logic [7:0] d_seen;
        launch(a, b, bin);
        chk({tag, ".accept_busy"}, 32'(bus_if.busy), 32'd1);
        wait_done(edges, bcnt, ovl);
        chk({tag, ".done_edge"}, 32'(edges), 32'(W));
        chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(W));
        chk({tag, ".busy_done_overlap"}, 32'(ovl), 32'd0);
        chk({tag, ".D"}, 32'(bus_if.D), 32'(ed));
        chk({tag, ".Bout"}, 32'(bus_if.Bout), 32'(eb));
        chk({tag, ".V"}, 32'(bus_if.V), 32'(ev));
        d_seen = bus_if.D;
        $display("op %s A=%02h B=%02h Bin=%0d -> D=%02h Bout=%0d V=%0d", tag, a, b, bin,
                 d_seen, bus_if.Bout, bus_if.V);
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, 32'(bus_if.done), 32'd0);
        chk({tag, ".D_hold"}, 32'(bus_if.D), 32'(ed));
    endtask

    initial begin
        int edges, bcnt, ovl, extra;
        logic [7:0] ra, rb, rd;
        logic       rbin, rbo, rv;
        logic [8:0] full;

        tbl[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
        tbl[1] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        bus_if.start = 1'b0;
        bus_if.A     = '0;
        bus_if.B     = '0;
        bus_if.Bin   = 1'b0;

        // Reset state
        #3;
        chk("rst.D", 32'(bus_if.D), 32'd0);
        chk("rst.Bout", 32'(bus_if.Bout), 32'd0);
        chk("rst.V", 32'(bus_if.V), 32'd0);
        chk("rst.busy", 32'(bus_if.busy), 32'd0);
        chk("rst.done", 32'(bus_if.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
                    tbl[i].d, tbl[i].bout, tbl[i].v);
        end

        // New start clears D but leaves Bout/V from 7F-FF; then reset mid-operation.
        launch(8'hAA, 8'h55, 1'b0);
        chk("restart.D_clear", 32'(bus_if.D), 32'd0);
        chk("restart.Bout_hold", 32'(bus_if.Bout), 32'd1);
        chk("restart.V_hold", 32'(bus_if.V), 32'd1);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.D", 32'(bus_if.D), 32'd0);
        chk("midrst.Bout", 32'(bus_if.Bout), 32'd0);
        chk("midrst.V", 32'(bus_if.V), 32'd0);
        chk("midrst.busy", 32'(bus_if.busy), 32'd0);
        chk("midrst.done", 32'(bus_if.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_rst", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);

        // Start pulsed during SHIFT must be ignored.
        launch(8'h50, 8'h20, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus_if.A     = 8'hFF;
        bus_if.B     = 8'h00;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        wait_done(edges, bcnt, ovl);
        chk("ignore.done_edge", 32'(edges + 3), 32'(W));
        chk("ignore.D", 32'(bus_if.D), 32'h30);
        chk("ignore.Bout", 32'(bus_if.Bout), 32'd0);
        chk("ignore.V", 32'(bus_if.V), 32'd0);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done || bus_if.busy) extra++;
        end
        chk("ignore.no_second_op", 32'(extra), 32'd0);
        $display("op ignore A=50 B=20 -> D=%02h", bus_if.D);

        // Start held high: operations back to back, WIDTH+2 clocks apart.
        @(negedge clk);
        bus_if.A     = 8'h03;
        bus_if.B     = 8'h01;
        bus_if.Bin   = 1'b0;
        bus_if.start = 1'b1;
        wait_done(edges, bcnt, ovl);
        chk("held.first_D", 32'(bus_if.D), 32'h02);
        @(posedge clk);
        #1;
        wait_done(edges, bcnt, ovl);
        chk("held.spacing", 32'(edges + 1), 32'(W + 2));
        chk("held.second_D", 32'(bus_if.D), 32'h02);
        bus_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held.stopped", 32'(bus_if.busy), 32'd0);
        $display("op held A=03 B=01 spacing=%0d", edges + 1);

        // Random sweep against a 9-bit arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            rd   = full[7:0];
            rbo  = full[8];
            rv   = (ra[7] != rb[7]) && (rd[7] != ra[7]);
            run_vec($sformatf("rnd%0d", i), ra, rb, rbin, rd, rbo, rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
